alu_seq: RTL and testbench

- Parametrised, registered successor to the single-cycle combinational ALU.
- Adds a valid/ready handshake, an internal flag register (PSR), carry-chained ADDC/SUBC that use the stored carry, and an iterative shift-add multiplier.
- Sits between the register-file read stage and the writeback stage of the CPU datapath.

---
 rtl/alu_seq.sv | 179 +++++++++++++++++
 tb/tb_alu_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a valid/ready handshake, a flag register (PSR),
// carry-chained ADDC/SUBC and an iterative shift-add unsigned multiplier.
// Single-cycle ops complete at their accept edge; MUL takes WIDTH edges.
module alu_seq #(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] Hi,
  output logic [4:0]       Flags,
  output logic             Busy
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0, OP_ADD  = 4'h1, OP_ADDC = 4'h2, OP_SUB  = 4'h3,
    OP_SUBC = 4'h4, OP_CMP  = 4'h5, OP_AND  = 4'h6, OP_OR   = 4'h7,
    OP_XOR  = 4'h8, OP_NOT  = 4'h9, OP_LSH  = 4'hA, OP_RSH  = 4'hB,
    OP_ARSH = 4'hC, OP_MUL  = 4'hD
  } op_e;

  typedef enum logic {S_IDLE, S_MUL} state_e;

  // Field order gives Flags[4:0] = {Carry, Flag, Low, Negative, Zero}.
  typedef struct packed {
    logic carry;
    logic flag;
    logic low;
    logic neg;
    logic zero;
  } psr_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] WLIM = WIDTH[WIDTH-1:0];

  state_e           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand, acc_hi, acc_lo;
  psr_t             psr_q, res_psr, mul_psr;
  logic [WIDTH-1:0] res_c;
  logic [WIDTH:0]   add_sum, sub_diff, step_sum;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             cin_add, cin_sub, accept, start_mul, single_done, finish_mul;

  assign Flags   = psr_q;
  assign Busy    = (state == S_MUL);
  assign InReady = (state == S_IDLE) && (!OutValid || OutReady);

  assign accept      = InValid && InReady;
  assign start_mul   = accept && MUL_EN && (Op == OP_MUL);
  assign single_done = accept && !start_mul;
  assign finish_mul  = (state == S_MUL) && (count == LAST);

  // Carry-in comes from the PSR as registered before the accept edge.
  assign cin_add  = (Op == OP_ADDC) && psr_q.carry;
  assign cin_sub  = (Op == OP_SUBC) && psr_q.carry;
  assign add_sum  = {1'b0, A} + {1'b0, B} + (WIDTH+1)'(cin_add);
  assign sub_diff = {1'b0, A} - {1'b0, B} - (WIDTH+1)'(cin_sub);

  // One multiplier bit per edge: conditionally add, then shift {hi,lo} right.
  assign step_sum = {1'b0, acc_hi} + {1'b0, mcand & {WIDTH{acc_lo[0]}}};
  assign step_hi  = step_sum[WIDTH:1];
  assign step_lo  = {step_sum[0], acc_lo[WIDTH-1:1]};

  // Result and flags of the single-cycle ops; NOP/reserved keep the PSR.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // otherwise an unlisted opcode would infer a latch.
    res_c   = '0;
    res_psr = psr_q;
    case (Op)
      OP_ADD, OP_ADDC: begin
        res_c         = add_sum[WIDTH-1:0];
        res_psr       = '0;
        res_psr.carry = add_sum[WIDTH];
        res_psr.flag  = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
        res_psr.low   = (A < B);
        res_psr.neg   = add_sum[WIDTH-1];
        res_psr.zero  = (add_sum[WIDTH-1:0] == '0);
      end
      OP_SUB, OP_SUBC: begin
        res_c         = sub_diff[WIDTH-1:0];
        res_psr       = '0;
        res_psr.carry = sub_diff[WIDTH];
        res_psr.flag  = (A[WIDTH-1] != B[WIDTH-1]) && (sub_diff[WIDTH-1] != A[WIDTH-1]);
        res_psr.low   = (A < B);
        res_psr.neg   = ($signed(A) < $signed(B));
        res_psr.zero  = (sub_diff[WIDTH-1:0] == '0);
      end
      OP_CMP: begin
        res_psr      = '0;
        res_psr.low  = (A < B);
        res_psr.neg  = ($signed(A) < $signed(B));
        res_psr.zero = (A == B);
      end
      OP_AND:  res_c = A & B;
      OP_OR:   res_c = A | B;
      OP_XOR:  res_c = A ^ B;
      OP_NOT:  res_c = ~A;
      OP_LSH:  res_c = (B >= WLIM) ? '0 : (A << B);
      OP_RSH:  res_c = (B >= WLIM) ? '0 : (A >> B);
      OP_ARSH: res_c = (B >= WLIM) ? {WIDTH{A[WIDTH-1]}} : WIDTH'($signed(A) >>> B);
      default: ;
    endcase
    // Logic and shift ops share one flag rule: only Zero/Negative from C.
    if (Op inside {OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LSH, OP_RSH, OP_ARSH}) begin
      res_psr      = '0;
      res_psr.neg  = res_c[WIDTH-1];
      res_psr.zero = (res_c == '0);
    end
  end

  // Flags written when the multiply completes.
  always_comb begin
    mul_psr       = '0;
    mul_psr.carry = (step_hi != '0);
    mul_psr.zero  = ({step_hi, step_lo} == '0);
  end

  // State, multiplier datapath and output registers; reset dominates.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!Reset) begin
      state    <= S_IDLE;
      count    <= '0;
      mcand    <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      OutValid <= 1'b0;
      C        <= '0;
      Hi       <= '0;
      psr_q    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_mul) begin
            state  <= S_MUL;
            count  <= '0;
            mcand  <= A;
            acc_hi <= '0;
            acc_lo <= B;
          end
        end
        S_MUL: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count + 1'b1;
          if (finish_mul) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (single_done) begin
        OutValid <= 1'b1;
        C        <= res_c;
        Hi       <= '0;
        psr_q    <= res_psr;
      end else if (finish_mul) begin
        OutValid <= 1'b1;
        C        <= step_lo;
        Hi       <= step_hi;
        psr_q    <= mul_psr;
      end else if (OutReady) begin
        OutValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=16, MUL_EN=1).
module tb_alu_seq;

  localparam int W = 16;

  localparam logic [3:0] NOP  = 4'h0, ADD = 4'h1, ADDC = 4'h2, SUB = 4'h3,
                         SUBC = 4'h4, CMP = 4'h5, AND_ = 4'h6, XOR_ = 4'h8,
                         NOT_ = 4'h9, RSH = 4'hB, ARSH = 4'hC, MUL = 4'hD,
                         RSVD = 4'hE;

  logic         Clk = 1'b0;
  logic         Reset, InValid, InReady, OutValid, OutReady, Busy;
  logic [3:0]   Op;
  logic [W-1:0] A, B, C, Hi;
  logic [4:0]   Flags;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .Op(Op), .A(A), .B(B), .OutValid(OutValid), .OutReady(OutReady),
    .C(C), .Hi(Hi), .Flags(Flags), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    Op = op; A = a; B = b; InValid = 1'b1;
  endtask

  initial begin
    int busy_cycles;
    int waited;
    bit seen_valid;

    Reset = 1'b0; InValid = 1'b0; OutReady = 1'b0; Op = NOP; A = '0; B = '0;

    // 1. reset
    repeat (3) step();
    Reset = 1'b1;
    check("rst_inready",  InReady,  1);
    check("rst_outvalid", OutValid, 0);
    check("rst_c",        C,        0);
    check("rst_hi",       Hi,       0);
    check("rst_flags",    Flags,    5'b00000);
    check("rst_busy",     Busy,     0);

    // 2. ADD then ADDC chained on the stored carry
    OutReady = 1'b1;
    issue(ADD, 16'hFFFF, 16'h0001); step();
    check("add_valid", OutValid, 1);
    check("add_c",     C,        16'h0000);
    check("add_hi",    Hi,       16'h0000);
    check("add_flags", Flags,    5'b10001);
    issue(ADDC, 16'h0000, 16'h0000); step();
    check("addc_c",     C,     16'h0001);
    check("addc_flags", Flags, 5'b00000);

    // 3. SUB overflow, SUB borrow into SUBC, CMP equal
    issue(SUB, 16'h8000, 16'h0001); step();
    check("sub_c",     C,     16'h7FFF);
    check("sub_flags", Flags, 5'b01010);
    issue(SUB, 16'h0000, 16'h0001); step();
    check("sub_brw_c",     C,     16'hFFFF);
    check("sub_brw_flags", Flags, 5'b10110);
    issue(SUBC, 16'h0005, 16'h0002); step();
    check("subc_c",     C,     16'h0002);
    check("subc_flags", Flags, 5'b00000);
    issue(CMP, 16'h0005, 16'h0005); step();
    check("cmp_c",     C,     16'h0000);
    check("cmp_flags", Flags, 5'b00001);
    InValid = 1'b0; step();
    check("drain_valid", OutValid, 0);

    // 4. MUL 0x0100*0x0100: busy for W cycles, result W edges after accept
    issue(MUL, 16'h0100, 16'h0100); step();
    InValid = 1'b0;
    busy_cycles = 0;
    waited = 0;
    while (!OutValid && waited < 40) begin
      if (Busy && !InReady) busy_cycles++;
      step();
      waited++;
    end
    check("mul_valid",   OutValid,    1);
    check("mul_latency", waited,      W);
    check("mul_busy",    busy_cycles, W);
    check("mul_c",       C,           16'h0000);
    check("mul_hi",      Hi,          16'h0001);
    check("mul_flags",   Flags,       5'b10000);
    check("mul_idle",    Busy,        0);
    step();

    // 5. back-pressure: ADD result held while AND waits on InValid
    OutReady = 1'b0;
    issue(ADD, 16'h0002, 16'h0003); step();
    issue(AND_, 16'hF0F0, 16'h0FF0);
    for (int k = 0; k < 3; k++) begin
      check("bp_inready", InReady, 0);
      check("bp_c",       C,       16'h0005);
      step();
    end
    check("bp_flags", Flags,    5'b00100);
    check("bp_valid", OutValid, 1);
    OutReady = 1'b1;
    #1;
    check("bp_release_inready", InReady, 1);
    step();
    InValid = 1'b0;
    check("and_valid", OutValid, 1);
    check("and_c",     C,        16'h00F0);
    check("and_flags", Flags,    5'b00000);

    // 6. reset in the middle of a MUL, then shifts and reserved op
    issue(ADD, 16'hFFFF, 16'h0001); step();
    issue(MUL, 16'h0100, 16'h0100); step();
    InValid = 1'b0;
    check("mul2_busy", Busy, 1);
    repeat (4) step();
    Reset = 1'b0; step(); Reset = 1'b1;
    check("mrst_busy",  Busy,     0);
    check("mrst_valid", OutValid, 0);
    check("mrst_flags", Flags,    5'b00000);
    check("mrst_c",     C,        16'h0000);
    check("mrst_hi",    Hi,       16'h0000);
    seen_valid = 1'b0;
    repeat (20) begin
      step();
      if (OutValid) seen_valid = 1'b1;
    end
    check("mrst_aborted", seen_valid, 0);

    issue(ARSH, 16'h8000, 16'd20); step();
    check("arsh_c",     C,     16'hFFFF);
    check("arsh_flags", Flags, 5'b00010);
    issue(RSVD, 16'h1234, 16'h0001); step();
    check("rsvd_valid", OutValid, 1);
    check("rsvd_c",     C,        16'h0000);
    check("rsvd_flags", Flags,    5'b00010);
    issue(RSH, 16'h8000, 16'd16); step();
    check("rsh_c",     C,     16'h0000);
    check("rsh_flags", Flags, 5'b00001);
    issue(NOT_, 16'h00FF, 16'h0000); step();
    check("not_c",     C,     16'hFF00);
    check("not_flags", Flags, 5'b00010);
    issue(XOR_, 16'hAAAA, 16'hAAAA); step();
    check("xor_c",     C,     16'h0000);
    check("xor_flags", Flags, 5'b00001);
    InValid = 1'b0; step();
    check("end_valid", OutValid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #50000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
